// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, ALU-op encodings and per-stage control bundles
// for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_RTYPE = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_SLT   = 3'd5
    } aluop_e;

    typedef struct packed {
        logic   regdst;
        logic   alusrc;
        aluop_e aluop;
        logic   branch;
        logic   bne;
        logic   jump;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   regwrite;
    } ctrl_t;

    // Only the fields still needed downstream are carried past EX.
    typedef struct packed {
        logic branch;
        logic bne;
        logic jump;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        mem_ctrl_t m;
        m.branch   = c.branch;
        m.bne      = c.bne;
        m.jump     = c.jump;
        m.memread  = c.memread;
        m.memwrite = c.memwrite;
        m.memtoreg = c.memtoreg;
        m.regwrite = c.regwrite;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.memtoreg = m.memtoreg;
        w.regwrite = m.regwrite;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decode: opcode and id_valid to control bundle,
// with an illegal flag for unknown opcodes on valid instructions.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       id_valid,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.regdst   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_RTYPE;
                end
                OP_LW: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_ADD;
                end
                OP_SW: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.memwrite = 1'b1;
                    ctrl.aluop    = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch = 1'b1;
                    ctrl.aluop  = ALU_SUB;
                end
                OP_BNE: begin
                    if (EN_BNE) begin
                        ctrl.branch = 1'b1;
                        ctrl.bne    = 1'b1;
                        ctrl.aluop  = ALU_SUB;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_ADDI: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_ADD;
                end
                OP_ANDI: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_AND;
                end
                OP_ORI: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_OR;
                end
                OP_SLTI: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_SLT;
                end
                OP_J: begin
                    if (EN_JUMP) ctrl.jump = 1'b1;
                    else         illegal   = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush and a saturating bubble counter.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_JUMP = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               flush,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [4:0]         ex_rt,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_branch,
    output logic               mem_bne,
    output logic               mem_jump,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic               stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   bubble_cnt
);

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    ctrl_t            idex_p0;
    logic [4:0]       ex_rt_p0;
    mem_ctrl_t        exmem_p1;
    wb_ctrl_t         memwb_p2;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard;
    logic             stall_int;
    logic [1:0]       bubble_inc;

    ctrl_decode #(
        .EN_BNE  (EN_BNE),
        .EN_JUMP (EN_JUMP)
    ) u_decode (
        .id_valid (id_valid),
        .opcode   (opcode),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // Two guard bits so a +2 from all-ones-minus-1 is caught as overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, a} + {{CNT_W{1'b0}}, inc};
        return (sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign hazard     = idex_p0.memread && (ex_rt_p0 != 5'd0) && id_valid &&
                        ((ex_rt_p0 == id_rs) || (ex_rt_p0 == id_rt));
    assign stall_int  = hazard && !flush;
    assign bubble_inc = flush ? 2'd2 : (stall_int ? 2'd1 : 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_p0   <= '0;
            ex_rt_p0  <= '0;
            exmem_p1  <= '0;
            memwb_p2  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // ID -> EX and EX -> MEM; the MEM instruction always retires.
            memwb_p2 <= to_wb(exmem_p1);
            if (flush) begin
                idex_p0  <= '0;
                ex_rt_p0 <= '0;
                exmem_p1 <= '0;
            end else if (stall_int) begin
                idex_p0  <= '0;
                ex_rt_p0 <= '0;
                exmem_p1 <= to_mem(idex_p0);
            end else begin
                idex_p0  <= dec_ctrl;
                ex_rt_p0 <= id_rt;
                exmem_p1 <= to_mem(idex_p0);
            end
            if (dec_illegal) illegal_q <= 1'b1;
            cnt_q <= sat_add(cnt_q, bubble_inc);
        end
    end

    assign ex_regdst    = idex_p0.regdst;
    assign ex_alusrc    = idex_p0.alusrc;
    assign ex_branch    = idex_p0.branch;
    assign ex_bne       = idex_p0.bne;
    assign ex_jump      = idex_p0.jump;
    assign ex_aluop     = ALUOP_W'(idex_p0.aluop);
    assign ex_rt        = ex_rt_p0;
    assign mem_memread  = exmem_p1.memread;
    assign mem_memwrite = exmem_p1.memwrite;
    assign mem_branch   = exmem_p1.branch;
    assign mem_bne      = exmem_p1.bne;
    assign mem_jump     = exmem_p1.jump;
    assign wb_regwrite  = memwb_p2.regwrite;
    assign wb_memtoreg  = memwb_p2.memtoreg;
    assign stall        = stall_int;
    assign pc_write     = !stall_int;
    assign ifid_write   = !stall_int;
    assign illegal_op   = illegal_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: a default instance and a reduced one (no bne/j,
// 3-bit aluop, 2-bit counter) driven in parallel against a slot-based model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] opcode;
    logic [4:0] id_rs, id_rt;
    logic       flush;

    logic a_ex_regdst, a_ex_alusrc, a_ex_branch, a_ex_bne, a_ex_jump;
    logic [3:0] a_ex_aluop;
    logic [4:0] a_ex_rt;
    logic a_mem_memread, a_mem_memwrite, a_mem_branch, a_mem_bne, a_mem_jump;
    logic a_wb_regwrite, a_wb_memtoreg, a_stall, a_pc_write, a_ifid_write, a_illegal_op;
    logic [15:0] a_bubble_cnt;

    logic b_ex_regdst, b_ex_alusrc, b_ex_branch, b_ex_bne, b_ex_jump;
    logic [2:0] b_ex_aluop;
    logic [4:0] b_ex_rt;
    logic b_mem_memread, b_mem_memwrite, b_mem_branch, b_mem_bne, b_mem_jump;
    logic b_wb_regwrite, b_wb_memtoreg, b_stall, b_pc_write, b_ifid_write, b_illegal_op;
    logic [1:0] b_bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .ex_regdst(a_ex_regdst), .ex_alusrc(a_ex_alusrc), .ex_branch(a_ex_branch),
        .ex_bne(a_ex_bne), .ex_jump(a_ex_jump), .ex_aluop(a_ex_aluop), .ex_rt(a_ex_rt),
        .mem_memread(a_mem_memread), .mem_memwrite(a_mem_memwrite), .mem_branch(a_mem_branch),
        .mem_bne(a_mem_bne), .mem_jump(a_mem_jump),
        .wb_regwrite(a_wb_regwrite), .wb_memtoreg(a_wb_memtoreg),
        .stall(a_stall), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .illegal_op(a_illegal_op), .bubble_cnt(a_bubble_cnt)
    );

    pipe_ctrl_unit #(.ALUOP_W(3), .EN_BNE(1'b0), .EN_JUMP(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .ex_regdst(b_ex_regdst), .ex_alusrc(b_ex_alusrc), .ex_branch(b_ex_branch),
        .ex_bne(b_ex_bne), .ex_jump(b_ex_jump), .ex_aluop(b_ex_aluop), .ex_rt(b_ex_rt),
        .mem_memread(b_mem_memread), .mem_memwrite(b_mem_memwrite), .mem_branch(b_mem_branch),
        .mem_bne(b_mem_bne), .mem_jump(b_mem_jump),
        .wb_regwrite(b_wb_regwrite), .wb_memtoreg(b_wb_memtoreg),
        .stall(b_stall), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .illegal_op(b_illegal_op), .bubble_cnt(b_bubble_cnt)
    );

    // Observed outputs in one common 41-bit layout (aluop and counter widened).
    logic [40:0] obs_a, obs_b;
    assign obs_a = {a_ex_regdst, a_ex_alusrc, a_ex_branch, a_ex_bne, a_ex_jump, a_ex_aluop, a_ex_rt,
                    a_mem_memread, a_mem_memwrite, a_mem_branch, a_mem_bne, a_mem_jump,
                    a_wb_regwrite, a_wb_memtoreg, a_stall, a_pc_write, a_ifid_write,
                    a_illegal_op, a_bubble_cnt};
    assign obs_b = {b_ex_regdst, b_ex_alusrc, b_ex_branch, b_ex_bne, b_ex_jump, {1'b0, b_ex_aluop}, b_ex_rt,
                    b_mem_memread, b_mem_memwrite, b_mem_branch, b_mem_bne, b_mem_jump,
                    b_wb_regwrite, b_wb_memtoreg, b_stall, b_pc_write, b_ifid_write,
                    b_illegal_op, {14'd0, b_bubble_cnt}};

    localparam logic [40:0] EXP_IDLE = 41'h0_0000_60000;

    // Reference model: each pipeline slot holds a whole decoded instruction.
    typedef struct packed {
        bit regdst, alusrc, branch, bne, jump, memread, memwrite, memtoreg, regwrite;
        bit [3:0] aluop;
        bit [4:0] rt;
    } slot_t;

    slot_t ex_s[2], mem_s[2], wb_s[2];
    bit    ill_s[2];
    int    cnt_s[2];
    int    cnt_max[2]  = '{65535, 3};
    bit    en_bne_c[2] = '{1'b1, 1'b0};
    bit    en_j_c[2]   = '{1'b1, 1'b0};

    function automatic slot_t ref_decode(input int c, output bit ill);
        slot_t s;
        s = '0;
        ill = 1'b0;
        if (id_valid) begin
            case (opcode)
                6'd0:  begin s.regdst = 1; s.regwrite = 1; s.aluop = 2; end
                6'd35: begin s.alusrc = 1; s.memread = 1; s.memtoreg = 1; s.regwrite = 1; end
                6'd43: begin s.alusrc = 1; s.memwrite = 1; end
                6'd4:  begin s.branch = 1; s.aluop = 1; end
                6'd5:  if (en_bne_c[c]) begin s.branch = 1; s.bne = 1; s.aluop = 1; end else ill = 1'b1;
                6'd8:  begin s.alusrc = 1; s.regwrite = 1; end
                6'd12: begin s.alusrc = 1; s.regwrite = 1; s.aluop = 3; end
                6'd13: begin s.alusrc = 1; s.regwrite = 1; s.aluop = 4; end
                6'd10: begin s.alusrc = 1; s.regwrite = 1; s.aluop = 5; end
                6'd2:  if (en_j_c[c]) s.jump = 1; else ill = 1'b1;
                default: ill = 1'b1;
            endcase
        end
        s.rt = id_rt;
        return s;
    endfunction

    function automatic bit ref_stall(input int c);
        return ex_s[c].memread && (ex_s[c].rt != 0) && id_valid &&
               ((ex_s[c].rt == id_rs) || (ex_s[c].rt == id_rt)) && !flush;
    endfunction

    function automatic logic [40:0] expect_vec(input int c);
        bit st;
        st = ref_stall(c);
        return {ex_s[c].regdst, ex_s[c].alusrc, ex_s[c].branch, ex_s[c].bne, ex_s[c].jump,
                ex_s[c].aluop, ex_s[c].rt,
                mem_s[c].memread, mem_s[c].memwrite, mem_s[c].branch, mem_s[c].bne, mem_s[c].jump,
                wb_s[c].regwrite, wb_s[c].memtoreg, st, !st, !st, ill_s[c], 16'(cnt_s[c])};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            ex_s[c] = '0; mem_s[c] = '0; wb_s[c] = '0; ill_s[c] = 1'b0; cnt_s[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit st, ill;
            slot_t d;
            st = ref_stall(c);
            d  = ref_decode(c, ill);
            wb_s[c]  = mem_s[c];
            mem_s[c] = flush ? '0 : ex_s[c];
            ex_s[c]  = (flush || st) ? '0 : d;
            if (ill) ill_s[c] = 1'b1;
            cnt_s[c] = cnt_s[c] + (flush ? 2 : (st ? 1 : 0));
            if (cnt_s[c] > cnt_max[c]) cnt_s[c] = cnt_max[c];
        end
    endtask

    // Called just after a rising edge; leaves time mid-cycle for sampling.
    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                         input bit fl);
        id_valid = v; opcode = op; id_rs = rs; id_rt = rt; flush = fl;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs_a !== EXP_IDLE) begin n_err++; $display("FAIL reset_a: got %h want %h", obs_a, EXP_IDLE); end
        n_vec++;
        if (obs_b !== EXP_IDLE) begin n_err++; $display("FAIL reset_b: got %h want %h", obs_b, EXP_IDLE); end
        reset = 1'b0;
        drive(1, 6'd35, 5'd1, 5'd9, 0);
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (a_ex_alusrc !== 1'b1) begin n_err++; $display("FAIL pre_reset_load: got %b want 1", a_ex_alusrc); end
        #1 reset = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (obs_a !== EXP_IDLE) begin n_err++; $display("FAIL async_reset: got %h want %h", obs_a, EXP_IDLE); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_lw_latency();
        drive(1, 6'd35, 5'd2, 5'd3, 0);
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (a_ex_alusrc !== 1'b1 || a_ex_aluop !== 4'd0) begin
            n_err++; $display("FAIL lw_ex: got alusrc=%b aluop=%0d want 1 0", a_ex_alusrc, a_ex_aluop);
        end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (a_mem_memread !== 1'b1) begin n_err++; $display("FAIL lw_mem: got %b want 1", a_mem_memread); end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if ({a_wb_regwrite, a_wb_memtoreg} !== 2'b11) begin
            n_err++; $display("FAIL lw_wb: got %b%b want 11", a_wb_regwrite, a_wb_memtoreg);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        drive(1, 6'd35, 5'd0, 5'd5, 0);
        tick();
        c0 = a_bubble_cnt;
        drive(1, 6'd0, 5'd5, 5'd6, 0);
        n_vec++;
        if ({a_stall, a_pc_write, a_ifid_write} !== 3'b100) begin
            n_err++; $display("FAIL load_use_stall: got %b%b%b want 100", a_stall, a_pc_write, a_ifid_write);
        end
        tick();
        drive(1, 6'd0, 5'd5, 5'd6, 0);
        n_vec++;
        if (a_stall !== 1'b0 || obs_a[40:27] !== 14'd0) begin
            n_err++; $display("FAIL load_use_bubble: got stall=%b ex=%h want 0 0", a_stall, obs_a[40:27]);
        end
        n_vec++;
        if (a_bubble_cnt !== c0 + 16'd1) begin
            n_err++; $display("FAIL load_use_cnt: got %0d want %0d", a_bubble_cnt, c0 + 16'd1);
        end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (a_ex_regdst !== 1'b1 || a_ex_aluop !== 4'd2 || a_ex_rt !== 5'd6) begin
            n_err++; $display("FAIL load_use_add: got regdst=%b aluop=%0d rt=%0d want 1 2 6",
                              a_ex_regdst, a_ex_aluop, a_ex_rt);
        end
        tick();
    endtask

    task automatic test_rt_zero();
        drive(1, 6'd35, 5'd0, 5'd0, 0);
        tick();
        drive(1, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (a_stall !== 1'b0 || a_pc_write !== 1'b1) begin
            n_err++; $display("FAIL rt_zero: got stall=%b pc_write=%b want 0 1", a_stall, a_pc_write);
        end
        tick();
    endtask

    task automatic test_flush_hazard();
        logic [15:0] c0;
        drive(1, 6'd35, 5'd0, 5'd7, 0);
        tick();
        c0 = a_bubble_cnt;
        drive(1, 6'd0, 5'd7, 5'd0, 1);
        n_vec++;
        if (a_stall !== 1'b0 || a_pc_write !== 1'b1) begin
            n_err++; $display("FAIL flush_stall: got stall=%b pc_write=%b want 0 1", a_stall, a_pc_write);
        end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (obs_a[40:22] !== 19'd0) begin
            n_err++; $display("FAIL flush_kill: got ex/mem=%h want 0", obs_a[40:22]);
        end
        n_vec++;
        if (a_bubble_cnt !== c0 + 16'd2) begin
            n_err++; $display("FAIL flush_cnt: got %0d want %0d", a_bubble_cnt, c0 + 16'd2);
        end
        tick();
    endtask

    task automatic test_illegal();
        drive(0, 6'd5, 5'd1, 5'd2, 0);
        tick();
        drive(1, 6'd5, 5'd1, 5'd2, 0);
        n_vec++;
        if (b_illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_invalid: got %b want 0", b_illegal_op); end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (b_illegal_op !== 1'b1 || obs_b[40:32] !== 9'd0) begin
            n_err++; $display("FAIL illegal_bne: got ill=%b ex=%h want 1 0", b_illegal_op, obs_b[40:32]);
        end
        n_vec++;
        if ({a_ex_branch, a_ex_bne, a_ex_aluop, a_illegal_op} !== 7'b1100010) begin
            n_err++; $display("FAIL legal_bne: got %b%b %0d %b want 11 1 0",
                              a_ex_branch, a_ex_bne, a_ex_aluop, a_illegal_op);
        end
        repeat (10) begin
            tick();
            drive(0, 6'd0, 5'd0, 5'd0, 0);
        end
        n_vec++;
        if (b_illegal_op !== 1'b1) begin n_err++; $display("FAIL illegal_sticky: got %b want 1", b_illegal_op); end
        tick();
    endtask

    task automatic test_cnt_sat();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 6'd0, 5'd0, 5'd0, 1);
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 1);
        n_vec++;
        if (b_bubble_cnt !== 2'd2) begin n_err++; $display("FAIL sat_first: got %0d want 2", b_bubble_cnt); end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 1);
        n_vec++;
        if (b_bubble_cnt !== 2'd3) begin n_err++; $display("FAIL sat_second: got %0d want 3", b_bubble_cnt); end
        tick();
        drive(0, 6'd0, 5'd0, 5'd0, 0);
        n_vec++;
        if (b_bubble_cnt !== 2'd3 || a_bubble_cnt !== 16'd6) begin
            n_err++; $display("FAIL sat_hold: got b=%0d a=%0d want 3 6", b_bubble_cnt, a_bubble_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ops[12] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2, 6'd35, 6'd35};
        logic [40:0] e;
        for (int i = 0; i < 400; i++) begin
            bit [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            drive($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0);
            e = expect_vec(0);
            n_vec++;
            if (obs_a !== e) begin n_err++; $display("FAIL rand_a[%0d]: got %h want %h", i, obs_a, e); end
            e = expect_vec(1);
            n_vec++;
            if (obs_b !== e) begin n_err++; $display("FAIL rand_b[%0d]: got %h want %h", i, obs_b, e); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; opcode = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
        model_reset();
        test_reset();
        test_lw_latency();
        test_load_use();
        test_rt_zero();
        test_flush_hazard();
        test_illegal();
        test_cnt_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
